// File: rtl/decode_pkg.sv
// decode_pkg: shared encodings for the RV32I/RV64I decode stage.
// Holds the major opcode constants, the control-field encodings seen by
// execute, the packed control word and a helper that builds one.
package decode_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [4:0] {
    EXE_X, EXE_ADD, EXE_SUB, EXE_AND, EXE_OR, EXE_XOR, EXE_SLL, EXE_SRL,
    EXE_SRA, EXE_SLT, EXE_SLTU, EXE_BEQ, EXE_BNE, EXE_BLT, EXE_BGE,
    EXE_BLTU, EXE_BGEU, EXE_JALR, EXE_COPY1, EXE_MUL, EXE_MULH,
    EXE_MULHSU, EXE_MULHU, EXE_DIV, EXE_DIVU, EXE_REM, EXE_REMU
  } exe_fun_e;

  typedef enum logic [1:0] {OP1_X, OP1_RS1, OP1_PC, OP1_IMZ} op1_e;

  typedef enum logic [2:0] {
    OP2_X, OP2_RS2, OP2_IMI, OP2_IMS, OP2_IMJ, OP2_IMU, OP2_IMB
  } op2_e;

  typedef enum logic [1:0] {MEN_X, MEN_S} mem_wen_e;

  typedef enum logic [2:0] {WB_X, WB_ALU, WB_MEM, WB_PC4, WB_CSR} wb_sel_e;

  typedef struct packed {
    exe_fun_e exe_fun;
    op1_e     op1;
    op2_e     op2;
    mem_wen_e mem_wen;
    logic     rf_wen;
    wb_sel_e  wb_sel;
    logic     illegal;
  } ctrl_t;

  // Undecodable words still travel down the pipe, but with every side
  // effect disabled and only the illegal flag set.
  localparam ctrl_t CTRL_ILLEGAL = '{exe_fun: EXE_X, op1: OP1_X, op2: OP2_X,
                                     mem_wen: MEN_X, rf_wen: 1'b0,
                                     wb_sel: WB_X, illegal: 1'b1};

  function automatic ctrl_t mk_ctrl(input exe_fun_e fn, input op1_e o1,
                                    input op2_e o2, input mem_wen_e mw,
                                    input logic rw, input wb_sel_e wb);
    return '{exe_fun: fn, op1: o1, op2: o2, mem_wen: mw, rf_wen: rw,
             wb_sel: wb, illegal: 1'b0};
  endfunction

endpackage

// File: rtl/decode_comb.sv
// decode_comb: purely combinational instruction decoder.
// Ports:
//   inst - 32-bit instruction word
//   ctrl - decoded control word (CTRL_ILLEGAL for undecodable encodings)
//   imm  - immediate chosen by ctrl.op2, sign-extended to XLEN (0 for RS2/X)
module decode_comb
  import decode_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int USE_M = 0
) (
  input  logic [31:0]     inst,
  output ctrl_t           ctrl,
  output logic [XLEN-1:0] imm
);

  localparam bit RV64  = (XLEN == 64);
  localparam bit HAS_M = (USE_M != 0);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [6:0] shift_hi;
  logic       ok;
  exe_fun_e   fn;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];
  // RV64 shift amounts are 6 bits wide, so bit 25 belongs to shamt there.
  assign shift_hi = RV64 ? {inst[31:26], 1'b0} : inst[31:25];

  always_comb begin
    // NOTE: every variable gets a value before the case so that no path
    // through the decode tree leaves one unassigned and infers a latch.
    ctrl = CTRL_ILLEGAL;
    fn   = EXE_X;
    ok   = 1'b0;
    case (opcode)
      OPC_LUI:   ctrl = mk_ctrl(EXE_ADD, OP1_X, OP2_IMU, MEN_X, 1'b1, WB_ALU);
      OPC_AUIPC: ctrl = mk_ctrl(EXE_ADD, OP1_PC, OP2_IMU, MEN_X, 1'b1, WB_ALU);
      OPC_JAL:   ctrl = mk_ctrl(EXE_ADD, OP1_PC, OP2_IMJ, MEN_X, 1'b1, WB_PC4);
      OPC_JALR:
        if (funct3 == 3'b000)
          ctrl = mk_ctrl(EXE_JALR, OP1_RS1, OP2_IMI, MEN_X, 1'b1, WB_PC4);
      OPC_BRANCH: begin
        ok = 1'b1;
        case (funct3)
          3'b000:  fn = EXE_BEQ;
          3'b001:  fn = EXE_BNE;
          3'b100:  fn = EXE_BLT;
          3'b101:  fn = EXE_BGE;
          3'b110:  fn = EXE_BLTU;
          3'b111:  fn = EXE_BGEU;
          default: ok = 1'b0;
        endcase
        if (ok) ctrl = mk_ctrl(fn, OP1_RS1, OP2_IMB, MEN_X, 1'b0, WB_X);
      end
      OPC_LOAD:
        if (funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5} ||
            (RV64 && funct3 inside {3'd3, 3'd6}))
          ctrl = mk_ctrl(EXE_ADD, OP1_RS1, OP2_IMI, MEN_X, 1'b1, WB_MEM);
      OPC_STORE:
        if (funct3 inside {3'd0, 3'd1, 3'd2} || (RV64 && funct3 == 3'd3))
          ctrl = mk_ctrl(EXE_ADD, OP1_RS1, OP2_IMS, MEN_S, 1'b0, WB_X);
      OPC_OP_IMM: begin
        ok = 1'b1;
        case (funct3)
          3'b000: fn = EXE_ADD;
          3'b010: fn = EXE_SLT;
          3'b011: fn = EXE_SLTU;
          3'b100: fn = EXE_XOR;
          3'b110: fn = EXE_OR;
          3'b111: fn = EXE_AND;
          3'b001: begin
            fn = EXE_SLL;
            ok = (shift_hi == 7'b0000000);
          end
          3'b101: begin
            // inst[30] separates SRAI from SRLI; all other upper bits are 0.
            fn = inst[30] ? EXE_SRA : EXE_SRL;
            ok = (shift_hi == 7'b0000000) || (shift_hi == 7'b0100000);
          end
        endcase
        if (ok) ctrl = mk_ctrl(fn, OP1_RS1, OP2_IMI, MEN_X, 1'b1, WB_ALU);
      end
      OPC_OP: begin
        if (funct7 == 7'b0000000) begin
          ok = 1'b1;
          case (funct3)
            3'b000: fn = EXE_ADD;
            3'b001: fn = EXE_SLL;
            3'b010: fn = EXE_SLT;
            3'b011: fn = EXE_SLTU;
            3'b100: fn = EXE_XOR;
            3'b101: fn = EXE_SRL;
            3'b110: fn = EXE_OR;
            3'b111: fn = EXE_AND;
          endcase
        end else if (funct7 == 7'b0100000) begin
          ok = (funct3 == 3'b000) || (funct3 == 3'b101);
          fn = (funct3 == 3'b000) ? EXE_SUB : EXE_SRA;
        end else if (funct7 == 7'b0000001 && HAS_M) begin
          ok = 1'b1;
          case (funct3)
            3'b000: fn = EXE_MUL;
            3'b001: fn = EXE_MULH;
            3'b010: fn = EXE_MULHSU;
            3'b011: fn = EXE_MULHU;
            3'b100: fn = EXE_DIV;
            3'b101: fn = EXE_DIVU;
            3'b110: fn = EXE_REM;
            3'b111: fn = EXE_REMU;
          endcase
        end
        if (ok) ctrl = mk_ctrl(fn, OP1_RS1, OP2_RS2, MEN_X, 1'b1, WB_ALU);
      end
      default: ;
    endcase
  end

  always_comb begin
    imm = '0;
    case (ctrl.op2)
      OP2_IMI: imm = XLEN'($signed(inst[31:20]));
      OP2_IMS: imm = XLEN'($signed({inst[31:25], inst[11:7]}));
      OP2_IMB: imm = XLEN'($signed({inst[31], inst[7], inst[30:25],
                                    inst[11:8], 1'b0}));
      OP2_IMJ: imm = XLEN'($signed({inst[31], inst[19:12], inst[20],
                                    inst[30:21], 1'b0}));
      OP2_IMU: imm = XLEN'($signed({inst[31:12], 12'b0}));
      default: ;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered decode pipeline stage between fetch and execute.
// Ports:
//   clk, rst_n          - rising-edge clock, async active-low reset
//   flush               - drop every held instruction (synchronous)
//   in_valid/in_ready   - fetch handshake carrying in_inst and in_pc
//   out_valid/out_ready - execute handshake
//   out_pc, exe_fun, op1, op2, mem_wen, rf_wen, wb_sel, rs1, rs2, rd, imm,
//   illegal             - decoded word of the oldest held instruction
// Decoding happens before storage, so both the main and the skid entry hold
// finished words and in_ready is a plain register with no path from
// out_ready.
module decode_stage
#(
  parameter int XLEN  = 32,
  parameter int USE_M = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      exe_fun,
  output logic [1:0]      op1,
  output logic [2:0]      op2,
  output logic [1:0]      mem_wen,
  output logic            rf_wen,
  output logic [2:0]      wb_sel,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  import decode_pkg::*;

  typedef struct packed {
    ctrl_t           ctrl;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
  } entry_t;

  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} state_e;

  ctrl_t           dec_ctrl;
  logic [XLEN-1:0] dec_imm;
  entry_t          dec_entry;
  entry_t          main_q;
  entry_t          skid_q;
  state_e          state;
  logic            do_accept;
  logic            do_release;

  decode_comb #(.XLEN(XLEN), .USE_M(USE_M)) u_decode (
    .inst (in_inst),
    .ctrl (dec_ctrl),
    .imm  (dec_imm)
  );

  assign dec_entry = '{ctrl: dec_ctrl, imm: dec_imm, pc: in_pc,
                       rs1: in_inst[19:15], rs2: in_inst[24:20],
                       rd: in_inst[11:7]};

  assign do_accept  = in_valid & in_ready;
  assign do_release = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the data entries are reset too, because every output must
      // read as zero (X encodings) while in reset, not only out_valid.
      state     <= ST_EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      main_q    <= '0;
      skid_q    <= '0;
    end else if (flush) begin
      // Flush beats any same-cycle accept or release; the offered word is
      // simply not captured.
      state     <= ST_EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every
      // branch below sees the pre-edge values of state, valid and ready.
      case (state)
        ST_EMPTY:
          if (do_accept) begin
            main_q    <= dec_entry;
            out_valid <= 1'b1;
            state     <= ST_ONE;
          end
        ST_ONE:
          if (do_accept && !do_release) begin
            skid_q   <= dec_entry;
            in_ready <= 1'b0;
            state    <= ST_TWO;
          end else if (do_release && !do_accept) begin
            out_valid <= 1'b0;
            state     <= ST_EMPTY;
          end else if (do_accept && do_release) begin
            main_q <= dec_entry;
          end
        ST_TWO:
          // in_ready is low here, so only a release can happen.
          if (do_release) begin
            main_q   <= skid_q;
            in_ready <= 1'b1;
            state    <= ST_ONE;
          end
        default: begin
          state     <= ST_EMPTY;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign out_pc  = main_q.pc;
  assign exe_fun = main_q.ctrl.exe_fun;
  assign op1     = main_q.ctrl.op1;
  assign op2     = main_q.ctrl.op2;
  assign mem_wen = main_q.ctrl.mem_wen;
  assign rf_wen  = main_q.ctrl.rf_wen;
  assign wb_sel  = main_q.ctrl.wb_sel;
  assign illegal = main_q.ctrl.illegal;
  assign rs1     = main_q.rs1;
  assign rs2     = main_q.rs2;
  assign rd      = main_q.rd;
  assign imm     = main_q.imm;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: scoreboard bench for decode_stage.
// Two instances share one stimulus stream: dut_a (XLEN=32, USE_M=0) and
// dut_b (XLEN=64, USE_M=1). Accepted words push hand-computed expectations
// into a per-instance queue; independent monitors compare whenever a word
// is presented and pop on release.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic [31:0] in_inst;
  logic [63:0] in_pc;

  logic        a_in_ready, a_out_valid, a_rf_wen, a_illegal;
  logic [31:0] a_out_pc, a_imm;
  logic [4:0]  a_exe, a_rs1, a_rs2, a_rd;
  logic [1:0]  a_op1, a_mem_wen;
  logic [2:0]  a_op2, a_wb;

  logic        b_in_ready, b_out_valid, b_rf_wen, b_illegal;
  logic [63:0] b_out_pc, b_imm;
  logic [4:0]  b_exe, b_rs1, b_rs2, b_rd;
  logic [1:0]  b_op1, b_mem_wen;
  logic [2:0]  b_op2, b_wb;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .USE_M(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_ready(a_in_ready), .in_inst(in_inst), .in_pc(in_pc[31:0]),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_pc(a_out_pc),
    .exe_fun(a_exe), .op1(a_op1), .op2(a_op2), .mem_wen(a_mem_wen),
    .rf_wen(a_rf_wen), .wb_sel(a_wb), .rs1(a_rs1), .rs2(a_rs2), .rd(a_rd),
    .imm(a_imm), .illegal(a_illegal)
  );

  decode_stage #(.XLEN(64), .USE_M(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_ready(b_in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_pc(b_out_pc),
    .exe_fun(b_exe), .op1(b_op1), .op2(b_op2), .mem_wen(b_mem_wen),
    .rf_wen(b_rf_wen), .wb_sel(b_wb), .rs1(b_rs1), .rs2(b_rs2), .rd(b_rd),
    .imm(b_imm), .illegal(b_illegal)
  );

  typedef struct {
    logic [31:0] inst;
    logic [4:0]  exe;
    logic [1:0]  op1;
    logic [2:0]  op2;
    logic [1:0]  mw;
    logic        rw;
    logic [2:0]  wb;
    logic        ill;
    logic [63:0] imm;   // expected 64-bit sign-extended immediate
    logic        m_op;  // M-extension word: illegal when USE_M=0
  } vec_t;

  typedef struct {
    logic [63:0] pc, imm;
    logic [4:0]  exe, rs1, rs2, rd;
    logic [1:0]  op1, mw;
    logic [2:0]  op2, wb;
    logic        rw, ill;
  } exp_t;

  vec_t vecs[14];
  exp_t q_a[$];
  exp_t q_b[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk_exp(input vec_t v, input logic [63:0] pc,
                                  input bit m_legal);
    exp_t e;
    e.pc  = pc;
    e.rs1 = v.inst[19:15];
    e.rs2 = v.inst[24:20];
    e.rd  = v.inst[11:7];
    if (v.m_op && !m_legal) begin
      e.exe = 5'd0; e.op1 = 2'd0; e.op2 = 3'd0; e.mw = 2'd0;
      e.rw  = 1'b0; e.wb  = 3'd0; e.ill = 1'b1; e.imm = 64'd0;
    end else begin
      e.exe = v.exe; e.op1 = v.op1; e.op2 = v.op2; e.mw = v.mw;
      e.rw  = v.rw;  e.wb  = v.wb;  e.ill = v.ill; e.imm = v.imm;
    end
    return e;
  endfunction

  // For illegal words only the forced fields and the raw register fields
  // carry a defined value.
  task automatic cmp(input string p, input exp_t e, input logic [63:0] pc,
                     input logic [63:0] imm, input logic [4:0] exe,
                     input logic [1:0] op1, input logic [2:0] op2,
                     input logic [1:0] mw, input logic rw,
                     input logic [2:0] wb, input logic ill,
                     input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic [4:0] rd);
    check({p, "_pc"}, pc, e.pc);
    check({p, "_exe_fun"}, 64'(exe), 64'(e.exe));
    check({p, "_mem_wen"}, 64'(mw), 64'(e.mw));
    check({p, "_rf_wen"}, 64'(rw), 64'(e.rw));
    check({p, "_illegal"}, 64'(ill), 64'(e.ill));
    check({p, "_regs"}, 64'({rs1, rs2, rd}), 64'({e.rs1, e.rs2, e.rd}));
    if (!e.ill) begin
      check({p, "_op1"}, 64'(op1), 64'(e.op1));
      check({p, "_op2"}, 64'(op2), 64'(e.op2));
      check({p, "_wb_sel"}, 64'(wb), 64'(e.wb));
      check({p, "_imm"}, imm, e.imm);
    end
  endtask

  // Monitors: compare on every presented cycle (also proves stability while
  // stalled), pop only when execute takes the word.
  always @(negedge clk) begin
    if (rst_n && !flush && a_out_valid) begin
      if (q_a.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL a_unexpected_word: got pc %0h expected none", a_out_pc);
      end else begin
        exp_t e;
        e = q_a[0];
        e.pc  = {32'd0, e.pc[31:0]};
        e.imm = {32'd0, e.imm[31:0]};
        cmp("a", e, {32'd0, a_out_pc}, {32'd0, a_imm}, a_exe, a_op1, a_op2,
            a_mem_wen, a_rf_wen, a_wb, a_illegal, a_rs1, a_rs2, a_rd);
        if (out_ready) void'(q_a.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && !flush && b_out_valid) begin
      if (q_b.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL b_unexpected_word: got pc %0h expected none", b_out_pc);
      end else begin
        cmp("b", q_b[0], b_out_pc, b_imm, b_exe, b_op1, b_op2, b_mem_wen,
            b_rf_wen, b_wb, b_illegal, b_rs1, b_rs2, b_rd);
        if (out_ready) void'(q_b.pop_front());
      end
    end
  end

  function automatic logic [63:0] pc_of(input int idx);
    return 64'hFFFF_0000_1000_0000 + 64'(idx * 4);
  endfunction

  // Offer vector idx until accepted (bounded); called at posedge+1.
  task automatic send(input int idx);
    bit done = 1'b0;
    in_inst  = vecs[idx].inst;
    in_pc    = pc_of(idx);
    in_valid = 1'b1;
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clk);
      if (a_in_ready) q_a.push_back(mk_exp(vecs[idx], pc_of(idx), 1'b0));
      if (b_in_ready) begin
        q_b.push_back(mk_exp(vecs[idx], pc_of(idx), 1'b1));
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      n_tests++; n_fail++;
      $display("FAIL send_timeout: vector %0d not accepted", idx);
    end
  endtask

  task automatic drain(input string tag);
    int c = 0;
    out_ready = 1'b1;
    while ((q_a.size() != 0 || q_b.size() != 0) && c < 100) begin
      @(posedge clk);
      c++;
    end
    @(posedge clk); #1;
    check({tag, "_a_left"}, 64'(q_a.size()), 64'd0);
    check({tag, "_b_left"}, 64'(q_b.size()), 64'd0);
    check({tag, "_out_valid"}, 64'({a_out_valid, b_out_valid}), 64'd0);
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_out_valid"}, 64'({a_out_valid, b_out_valid}), 64'd0);
    check({tag, "_in_ready"}, 64'({a_in_ready, b_in_ready}), 64'd3);
    check({tag, "_a_ctrl"}, 64'({a_exe, a_op1, a_op2, a_mem_wen, a_rf_wen,
                                 a_wb, a_illegal}), 64'd0);
    check({tag, "_b_ctrl"}, 64'({b_exe, b_op1, b_op2, b_mem_wen, b_rf_wen,
                                 b_wb, b_illegal}), 64'd0);
    check({tag, "_a_data"}, {a_out_pc, a_imm}, 64'd0);
    check({tag, "_a_regs"}, 64'({a_rs1, a_rs2, a_rd}), 64'd0);
    check({tag, "_b_pc"}, b_out_pc, 64'd0);
    check({tag, "_b_imm"}, b_imm, 64'd0);
    check({tag, "_b_regs"}, 64'({b_rs1, b_rs2, b_rd}), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    //            inst          exe   op1   op2   mw    rw    wb    ill   imm                      m_op
    vecs[0]  = '{32'hFFB10093, 5'd1, 2'd1, 3'd2, 2'd0, 1'b1, 3'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFB, 1'b0}; // addi x1,x2,-5
    vecs[1]  = '{32'h00532423, 5'd1, 2'd1, 3'd3, 2'd1, 1'b0, 3'd0, 1'b0, 64'h0000_0000_0000_0008, 1'b0}; // sw x5,8(x6)
    vecs[2]  = '{32'h022081B3, 5'd19,2'd1, 3'd1, 2'd0, 1'b1, 3'd1, 1'b0, 64'h0,                   1'b1}; // mul x3,x1,x2
    vecs[3]  = '{32'hFE000EE3, 5'd11,2'd1, 3'd6, 2'd0, 1'b0, 3'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0}; // beq -4
    vecs[4]  = '{32'h123452B7, 5'd1, 2'd0, 3'd5, 2'd0, 1'b1, 3'd1, 1'b0, 64'h0000_0000_1234_5000, 1'b0}; // lui x5
    vecs[5]  = '{32'hFFFFF517, 5'd1, 2'd2, 3'd5, 2'd0, 1'b1, 3'd1, 1'b0, 64'hFFFF_FFFF_FFFF_F000, 1'b0}; // auipc x10
    vecs[6]  = '{32'hFF9FF0EF, 5'd1, 2'd2, 3'd4, 2'd0, 1'b1, 3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0}; // jal x1,-8
    vecs[7]  = '{32'h40325193, 5'd8, 2'd1, 3'd2, 2'd0, 1'b1, 3'd1, 1'b0, 64'h0000_0000_0000_0403, 1'b0}; // srai x3,x4,3
    vecs[8]  = '{32'h407302B3, 5'd2, 2'd1, 3'd1, 2'd0, 1'b1, 3'd1, 1'b0, 64'h0,                   1'b0}; // sub x5,x6,x7
    vecs[9]  = '{32'hFFFFFFFF, 5'd0, 2'd0, 3'd0, 2'd0, 1'b0, 3'd0, 1'b1, 64'h0,                   1'b0}; // bad opcode
    vecs[10] = '{32'hFFC4A403, 5'd1, 2'd1, 3'd2, 2'd0, 1'b1, 3'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0}; // lw x8,-4(x9)
    vecs[11] = '{32'h00008067, 5'd17,2'd1, 3'd2, 2'd0, 1'b1, 3'd3, 1'b0, 64'h0,                   1'b0}; // jalr x0,0(x1)
    vecs[12] = '{32'h0020E863, 5'd15,2'd1, 3'd6, 2'd0, 1'b0, 3'd0, 1'b0, 64'h0000_0000_0000_0010, 1'b0}; // bltu +16
    vecs[13] = '{32'h002081BB, 5'd0, 2'd0, 3'd0, 2'd0, 1'b0, 3'd0, 1'b1, 64'h0,                   1'b0}; // addw (RV64 W-op)

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_inst = 32'd0; in_pc = 64'd0;
    repeat (2) @(posedge clk);
    #1;
    check_idle_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // First word from EMPTY appears one cycle after acceptance.
    out_ready = 1'b1;
    send(0);
    check("latency_out_valid", 64'({a_out_valid, b_out_valid}), 64'd3);
    // Back-to-back stream at full rate.
    for (int i = 1; i < 14; i++) send(i);
    drain("stream");

    // Stall: two words fill main and skid, the third waits.
    out_ready = 1'b0;
    @(posedge clk); #1;
    send(4);
    check("one_in_ready", 64'({a_in_ready, b_in_ready}), 64'd3);
    send(5);
    check("two_in_ready", 64'({a_in_ready, b_in_ready}), 64'd0);
    in_inst = vecs[6].inst; in_pc = pc_of(6); in_valid = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    check("two_hold_in_ready", 64'({a_in_ready, b_in_ready}), 64'd0);
    out_ready = 1'b1;
    send(6);
    drain("skid");

    // Flush while TWO with a word offered.
    out_ready = 1'b0;
    send(7);
    send(8);
    in_inst = vecs[9].inst; in_pc = pc_of(9); in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    q_a.delete(); q_b.delete();
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush2_out_valid", 64'({a_out_valid, b_out_valid}), 64'd0);
    check("flush2_in_ready", 64'({a_in_ready, b_in_ready}), 64'd3);

    // Flush in ONE beats a simultaneous accept and release.
    send(10);
    in_inst = vecs[11].inst; in_pc = pc_of(11); in_valid = 1'b1;
    out_ready = 1'b1; flush = 1'b1;
    @(negedge clk);
    q_a.delete(); q_b.delete();
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush1_out_valid", 64'({a_out_valid, b_out_valid}), 64'd0);
    check("flush1_in_ready", 64'({a_in_ready, b_in_ready}), 64'd3);
    send(12);
    drain("post_flush");

    // Asynchronous reset mid-stream, away from any clock edge.
    out_ready = 1'b0;
    send(0);
    send(1);
    #3;
    rst_n = 1'b0;
    #1;
    check_idle_zero("async_reset");
    q_a.delete(); q_b.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(3);
    drain("post_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
